axi_read_arbiter: RTL and testbench
===================================

// Module: axi_read_arbiter
// PURPOSE
//  Shares the single AXI3 read port (AR + R channels) between two refill masters:
//  port 0 = instruction cache controller, port 1 = data cache controller.
//  Serialises whole bursts: one outstanding read at a time, grant held from AR handshake to RLAST.
//  Round-robin between ports; sits between the IF/MEM cache controllers and the AXI interconnect.
// PARAMETERS
//  ADDR_W  32  address width
//  DATA_W  32  read data width
//  LEN_W   4   ARLEN width (AXI3: beats = ARLEN+1, max 16)
// PORTS
//  clk          in   1         clock, rising edge
//  rst          in   1         asynchronous, active-high reset
//  s_araddr     in   2*ADDR_W  per-port read address; port n at [n*ADDR_W +: ADDR_W]
//  s_arlen      in   2*LEN_W   per-port burst length
//  s_arvalid    in   2         per-port address valid
//  s_arready    out  2         per-port address accepted
//  s_rdata      out  DATA_W    read data, broadcast to both ports
//  s_rlast      out  1         last beat, broadcast to both ports
//  s_rvalid     out  2         per-port data valid; only the granted bit can be 1
//  s_rready     in   2         per-port data ready
//  m_araddr     out  ADDR_W    AXI read address
//  m_arlen      out  LEN_W     AXI burst length
//  m_arburst    out  2         constant 2'b01 (INCR)
//  m_arvalid    out  1         AXI address valid
//  m_arready    in   1         AXI address ready
//  m_rdata      in   DATA_W    AXI read data
//  m_rlast      in   1         AXI last beat
//  m_rvalid     in   1         AXI data valid
//  m_rready     out  1         AXI data ready
//  grant        out  1         index of the port currently or last served
//  busy         out  1         1 in ADDR or DATA state
//  len_err      out  1         sticky: RLAST position disagreed with ARLEN
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, last_grant=1 (port 0 wins first tie), beat_cnt=0, len_err=0;
//   m_arvalid=0, s_arready=0, s_rvalid=0, m_rready=0, busy=0.
//  FSM IDLE -> ADDR -> DATA -> IDLE.
//  IDLE: if any s_arvalid, register grant (round-robin: when both request, take the port
//   != last_grant; otherwise take the sole requester), latch araddr/arlen, go to ADDR.
//   No requests: stay in IDLE.
//  ADDR: m_arvalid=1, driven from the latched addr/len. Address and length are stable
//   until the handshake. When m_arready=1: s_arready[grant] pulses for exactly that cycle,
//   beat_cnt<=0, go to DATA.
//   Minimum latency: s_arvalid seen in cycle T -> m_arvalid in T+1.
//  DATA: m_rready=s_rready[grant]; s_rvalid[grant]=m_rvalid; the other s_rvalid bit=0.
//   Data passes through combinationally, with no buffering.
//   On each beat (m_rvalid & m_rready): beat_cnt++.
//   On a beat with m_rlast: last_grant<=grant, go to IDLE.
//   len_err<=1 if m_rlast arrives while beat_cnt!=arlen, or if beat_cnt==arlen without m_rlast.
//   On the second case, keep waiting for m_rlast.
//  A request on the non-granted port during ADDR/DATA is held off (s_arready=0) and is
//   served in the next IDLE. Bursts are back-to-back with 1 IDLE cycle between them.
//  Simultaneous first requests after reset: port 0 wins.
//  Reset mid-burst: everything returns to reset values immediately. Any data beats still
//   in flight downstream are the interconnect's concern; the arbiter does not drain them.
//  s_arvalid deassert before grant: the latched request is still issued.
//   The caches must not retract a request.
// TESTING
//  1. Port 0 req addr 0x1000 len 15, m_arready=1 -> m_arvalid at T+1; 16 beats routed to port 0; s_rvalid[1]=0 throughout.
//  2. Both ports request in the same cycle after reset -> port 0 served first, then port 1, with 1 IDLE cycle between bursts.
//  3. Both ports hold requests continuously for 4 bursts -> grants alternate 0,1,0,1.
//  4. s_rready[grant] toggles 0/1 each cycle, m_rvalid=1 -> m_rready follows it; exactly 16 beats transferred, no data dropped.
//  5. rst asserted on beat 5 of 16 -> m_rready=0, s_rvalid=0, busy=0 in the same cycle; a new request is served cleanly afterwards.
//  6. arlen=3 but m_rlast on beat 2 -> len_err=1 and stays set; FSM returns to IDLE.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// Two-port round-robin arbiter for a single AXI3 read port. Each granted burst
// runs from the AR handshake to RLAST before the next port is served.
//
// state | meaning
// IDLE  | no burst active; picks the next requester and latches its AR fields
// ADDR  | presenting latched address/length on the AXI AR channel
// DATA  | routing R beats between the AXI port and the granted master
module axi_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*ADDR_W-1:0] s_araddr,
  input  logic [2*LEN_W-1:0]  s_arlen,
  input  logic [1:0]          s_arvalid,
  output logic [1:0]          s_arready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic                s_rlast,
  output logic [1:0]          s_rvalid,
  input  logic [1:0]          s_rready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [LEN_W-1:0]    m_arlen,
  output logic [1:0]          m_arburst,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic                grant,
  output logic                busy,
  output logic                len_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state;
  logic              last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_cnt;
  logic              nxt_grant;
  logic              beat;
  logic [1:0]        grant_oh;

  // On a tie the port that was not served last wins.
  always_comb begin
    nxt_grant = grant;
    if (&s_arvalid)       nxt_grant = ~last_grant;
    else if (s_arvalid[1]) nxt_grant = 1'b1;
    else if (s_arvalid[0]) nxt_grant = 1'b0;
  end

  assign grant_oh = grant ? 2'b10 : 2'b01;
  assign beat     = (state == DATA) & m_rvalid & m_rready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt   <= '0;
      len_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|s_arvalid) begin
            grant  <= nxt_grant;
            addr_q <= nxt_grant ? s_araddr[2*ADDR_W-1:ADDR_W] : s_araddr[ADDR_W-1:0];
            len_q  <= nxt_grant ? s_arlen[2*LEN_W-1:LEN_W] : s_arlen[LEN_W-1:0];
            state  <= ADDR;
          end
        end
        ADDR: begin
          if (m_arready) begin
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (m_rlast) begin
              if (beat_cnt != len_q) len_err <= 1'b1;
              last_grant <= grant;
              state      <= IDLE;
            end else if (beat_cnt == len_q) begin
              // Slave overran the requested length; keep draining until RLAST.
              len_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_arvalid = (state == ADDR);
  assign m_araddr  = addr_q;
  assign m_arlen   = len_q;
  assign m_arburst = 2'b01;
  assign s_arready = (state == ADDR && m_arready) ? grant_oh : 2'b00;
  assign m_rready  = (state == DATA) & (grant ? s_rready[1] : s_rready[0]);
  assign s_rvalid  = (state == DATA && m_rvalid) ? grant_oh : 2'b00;
  assign s_rdata   = m_rdata;
  assign s_rlast   = m_rlast;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: single bursts, arbitration order,
// R-channel backpressure, reset mid-burst and length-error detection.
module tb_axi_read_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [1:0]  s_arvalid, s_arready;
  logic [31:0] s_rdata;
  logic        s_rlast;
  logic [1:0]  s_rvalid, s_rready;
  logic [31:0] m_araddr;
  logic [3:0]  m_arlen;
  logic [1:0]  m_arburst;
  logic        m_arvalid, m_arready;
  logic [31:0] m_rdata;
  logic        m_rlast, m_rvalid, m_rready;
  logic        grant, busy, len_err;

  int n_pass = 0;
  int n_total = 0;

  axi_read_arbiter dut (
    .clk(clk), .rst(rst),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arburst(m_arburst), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready), .grant(grant), .busy(busy), .len_err(len_err)
  );

  always #5 clk = ~clk;

  // Call with the request already driven, before the posedge where IDLE samples it.
  // Returns just after the posedge that accepts the RLAST beat, or right after
  // driving beat number 'abort' (abort < 0 disables that).
  task automatic do_burst(input int p, input int len, input int rlast_at, input bit tog,
                          input bit keep, input int stall, input int abort);
    logic [31:0] exp_addr, d;
    logic [1:0]  pbit;
    logic [63:0] saved;
    logic        rr, rl;
    int          beat, cyc;
    bit          done;
    exp_addr = (p == 1) ? 32'h0000_2000 : 32'h0000_1000;
    pbit     = (p == 1) ? 2'b10 : 2'b01;
    @(posedge clk);
    @(negedge clk);
    m_arready = 1'b0;
    #1;
    n_total++;
    if ({m_arvalid, grant, busy, m_araddr, m_arlen, m_arburst, s_arready} !==
        {1'b1, p[0], 1'b1, exp_addr, len[3:0], 2'b01, 2'b00})
      $display("FAIL addr_phase: got v%b g%b b%b a%h l%h bu%b rdy%b expected g%0d a%h l%0d",
               m_arvalid, grant, busy, m_araddr, m_arlen, m_arburst, s_arready, p, exp_addr, len);
    else n_pass++;
    saved = s_araddr;
    for (int i = 0; i < stall; i++) begin
      s_araddr = ~saved;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_total++;
      if ({m_arvalid, m_araddr} !== {1'b1, exp_addr})
        $display("FAIL addr_stable: got v%b a%h expected v1 a%h", m_arvalid, m_araddr, exp_addr);
      else n_pass++;
    end
    s_araddr  = saved;
    m_arready = 1'b1;
    #1;
    n_total++;
    if (s_arready !== pbit)
      $display("FAIL arready_pulse: got %b expected %b", s_arready, pbit);
    else n_pass++;
    if (!keep) s_arvalid = s_arvalid & ~pbit;
    @(posedge clk);
    beat = 0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      m_arready = 1'b0;
      d  = 32'hA000_0000 + 32'(p << 16) + 32'(beat);
      rl = (beat == rlast_at);
      rr = tog ? cyc[0] : 1'b1;
      m_rvalid  = 1'b1;
      m_rdata   = d;
      m_rlast   = rl;
      s_rready  = {rr, rr};
      if (beat == abort) return;
      #1;
      n_total++;
      if ({m_rready, s_rvalid, s_rdata, s_rlast} !== {rr, pbit, d, rl})
        $display("FAIL beat%0d: got rr%b sv%b d%h l%b expected rr%b sv%b d%h l%b",
                 beat, m_rready, s_rvalid, s_rdata, s_rlast, rr, pbit, d, rl);
      else n_pass++;
      @(posedge clk);
      if (rr) begin
        if (beat == rlast_at) done = 1'b1;
        beat++;
      end
      cyc++;
    end
    if (!done) begin
      n_total++;
      $display("FAIL data_timeout: got %0d beats expected %0d", beat, rlast_at + 1);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_araddr = {32'h0000_2000, 32'h0000_1000};
    s_arlen = 8'h00; s_arvalid = 2'b00; s_rready = 2'b00;
    m_arready = 1'b0; m_rdata = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if ({busy, m_arvalid, s_arready, s_rvalid, m_rready, grant, len_err} !== 9'b0)
      $display("FAIL reset_held: got %b expected 0",
               {busy, m_arvalid, s_arready, s_rvalid, m_rready, grant, len_err});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_total++;
    if ({busy, m_arvalid, grant, len_err, m_arburst} !== 6'b000001)
      $display("FAIL reset_release: got b%b v%b g%b e%b bu%b expected 0 0 0 0 01",
               busy, m_arvalid, grant, len_err, m_arburst);
    else n_pass++;
  endtask

  task automatic gap_check(input string name, input logic eg, input logic ee);
    @(negedge clk);
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    n_total++;
    if ({busy, m_arvalid, s_rvalid, grant, len_err} !== {1'b0, 1'b0, 2'b00, eg, ee})
      $display("FAIL %s: got b%b v%b sv%b g%b e%b expected b0 v0 sv00 g%b e%b",
               name, busy, m_arvalid, s_rvalid, grant, len_err, eg, ee);
    else n_pass++;
  endtask

  task automatic test_single();
    s_arlen = {4'd15, 4'd15};
    @(negedge clk);
    s_arvalid = 2'b01;
    do_burst(0, 15, 15, 1'b0, 1'b0, 2, -1);
    gap_check("single_end", 1'b0, 1'b0);
  endtask

  task automatic test_arbitration();
    apply_reset();
    s_arlen = {4'd3, 4'd1};
    s_arvalid = 2'b11;
    do_burst(0, 1, 1, 1'b0, 1'b0, 0, -1);
    gap_check("tie_gap", 1'b0, 1'b0);
    do_burst(1, 3, 3, 1'b0, 1'b0, 0, -1);
    gap_check("tie_second", 1'b1, 1'b0);
  endtask

  task automatic test_round_robin();
    s_arlen = {4'd2, 4'd2};
    @(negedge clk);
    s_arvalid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      do_burst(i % 2, 2, 2, 1'b0, 1'b1, 0, -1);
      if (i == 3) s_arvalid = 2'b00;
      gap_check("rr_gap", 1'(i % 2), 1'b0);
    end
  endtask

  task automatic test_backpressure();
    s_arlen = {4'd2, 4'd15};
    @(negedge clk);
    s_arvalid = 2'b01;
    do_burst(0, 15, 15, 1'b1, 1'b0, 0, -1);
    gap_check("bp_end", 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    s_arvalid = 2'b01;
    do_burst(0, 15, 15, 1'b0, 1'b0, 0, 5);
    rst = 1'b1;
    #1;
    n_total++;
    if ({m_rready, s_rvalid, busy, m_arvalid, grant} !== 6'b0)
      $display("FAIL reset_mid: got rr%b sv%b b%b v%b g%b expected all 0",
               m_rready, s_rvalid, busy, m_arvalid, grant);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    m_rvalid = 1'b0;
    s_arlen = {4'd1, 4'd15};
    s_arvalid = 2'b10;
    do_burst(1, 1, 1, 1'b0, 1'b0, 0, -1);
    gap_check("after_reset", 1'b1, 1'b0);
  endtask

  task automatic test_len_err();
    s_arlen = {4'd1, 4'd3};
    @(negedge clk);
    s_arvalid = 2'b01;
    do_burst(0, 3, 2, 1'b0, 1'b0, 0, -1);
    gap_check("len_err_set", 1'b0, 1'b1);
    s_arvalid = 2'b01;
    do_burst(0, 3, 3, 1'b0, 1'b0, 0, -1);
    gap_check("len_err_sticky", 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_round_robin();
    test_backpressure();
    test_reset_mid_burst();
    test_len_err();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
